// File: rtl/sipo_deframer.sv
// sipo_deframer: assembles LSB-first serial bits into WIDTH-bit words and
// presents them through a one-word holding register with a sticky overrun flag.
module sipo_deframer #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             s_in,
  input  logic             flush,
  input  logic             word_ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shifted;
  logic             capture;
  logic             complete;
  logic             drain;
  logic             accept;
  logic             drop;

  // Handshake: a word transfers on a rising edge where word_valid and
  // word_ready are both high; word_out is held stable until that edge.
  assign shifted  = {s_in, shift_reg[WIDTH-1:1]};
  assign capture  = bit_valid & ~flush;
  assign complete = capture & (bit_count == LAST);
  assign drain    = word_valid & word_ready;
  assign accept   = complete & (~word_valid | drain);
  assign drop     = complete & word_valid & ~word_ready;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      shift_reg <= '0;
      bit_count <= '0;
    end else if (flush) begin
      shift_reg <= '0;
      bit_count <= '0;
    end else if (bit_valid) begin
      shift_reg <= shifted;
      bit_count <= complete ? '0 : bit_count + CNT_W'(1);
    end
  end

  // Completion into a free (or simultaneously draining) slot wins over drain.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      word_out   <= '0;
      word_valid <= 1'b0;
    end else if (accept) begin
      word_out   <= shifted;
      word_valid <= 1'b1;
    end else if (drain) begin
      word_valid <= 1'b0;
    end
  end

  // Set-dominant: a drop in the same cycle as clr_ovr leaves overrun set.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_deframer.sv
// tb_sipo_deframer: directed and randomized bit streams checked against a
// queue-based word model; a negedge monitor scores every presented word.
module tb_sipo_deframer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clear = 1'b0;
  logic         bit_valid = 1'b0;
  logic         s_in = 1'b0;
  logic         flush = 1'b0;
  logic         word_ready = 1'b0;
  logic         clr_ovr = 1'b0;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         overrun;
  logic [2:0]   bit_count;

  logic [W-1:0] exp_q[$];
  bit           m_bits[$];
  bit           m_pending = 1'b0;
  bit           m_ovr = 1'b0;
  int           checks = 0;
  int           errors = 0;

  sipo_deframer #(.WIDTH(W)) dut (
    .clk        (clk),
    .clear      (clear),
    .bit_valid  (bit_valid),
    .s_in       (s_in),
    .flush      (flush),
    .word_ready (word_ready),
    .clr_ovr    (clr_ovr),
    .word_out   (word_out),
    .word_valid (word_valid),
    .overrun    (overrun),
    .bit_count  (bit_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (clear && word_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 32'(word_out), 32'hFFFF_FFFF);
      end else begin
        chk("word_out", 32'(word_out), 32'(exp_q[0]));
        if (word_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver: one clock of stimulus plus model update ----------------
  task automatic cycle(input bit bv, input bit b, input bit fl, input bit rdy, input bit co);
    logic [W-1:0] w;
    bit consumed;
    bit accepted;
    bit drop;
    bit_valid  = bv;
    s_in       = b;
    flush      = fl;
    word_ready = rdy;
    clr_ovr    = co;
    consumed = m_pending && rdy;
    accepted = 1'b0;
    drop     = 1'b0;
    if (fl) begin
      m_bits.delete();
    end else if (bv) begin
      m_bits.push_back(b);
      if (m_bits.size() == W) begin
        w = '0;
        foreach (m_bits[i]) w[i] = m_bits[i];
        m_bits.delete();
        if (!m_pending || consumed) begin
          exp_q.push_back(w);
          m_pending = 1'b1;
          accepted  = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end
    if (consumed && !accepted) m_pending = 1'b0;
    if (drop) m_ovr = 1'b1;
    else if (co) m_ovr = 1'b0;
    @(posedge clk);
    #1;
    chk("bit_count", 32'(bit_count), 32'(m_bits.size()));
    chk("word_valid", 32'(word_valid), 32'(m_pending));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic idle(input int n, input bit rdy, input bit co);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, rdy, co);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit rdy, input bit last_rdy);
    for (int i = 0; i < W; i++) cycle(1'b1, w[i], 1'b0, (i == W - 1) ? last_rdy : rdy, 1'b0);
  endtask

  // Asserts clear between edges and checks outputs before the next edge.
  task automatic reset_mid_cycle();
    clear = 1'b0;
    #2;
    chk("rst_word_out", 32'(word_out), 32'h0);
    chk("rst_word_valid", 32'(word_valid), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_bit_count", 32'(bit_count), 32'h0);
    m_bits.delete();
    exp_q.delete();
    m_pending = 1'b0;
    m_ovr     = 1'b0;
    @(posedge clk);
    #1;
    clear = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] gw;
    #2;
    chk("init_word_out", 32'(word_out), 32'h0);
    chk("init_word_valid", 32'(word_valid), 32'h0);
    chk("init_overrun", 32'(overrun), 32'h0);
    chk("init_bit_count", 32'(bit_count), 32'h0);
    @(posedge clk);
    #1;
    clear = 1'b1;

    // basic word 8'hA5, then drain
    send_word(8'hA5, 1'b1, 1'b1);
    idle(2, 1'b1, 1'b0);

    // gapped 8'h3C with gaps after bits 2 and 6
    gw = 8'h3C;
    for (int i = 0; i < W; i++) begin
      cycle(1'b1, gw[i], 1'b0, 1'b1, 1'b0);
      if (i == 2 || i == 6) idle(3, 1'b1, 1'b0);
    end
    idle(2, 1'b1, 1'b0);

    // backpressure: second word dropped, overrun sticks until cleared
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);
    idle(1, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b1);

    // back-to-back: second completion drains the first in the same edge
    send_word(8'hF0, 1'b0, 1'b0);
    send_word(8'h0F, 1'b0, 1'b1);
    idle(2, 1'b1, 1'b0);

    // flush mid-frame with a simultaneous bit
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    send_word(8'h5A, 1'b1, 1'b1);
    idle(2, 1'b1, 1'b0);

    // reset mid-frame, and again while a word is held with overrun set
    for (int i = 0; i < 5; i++) cycle(1'b1, i[0], 1'b0, 1'b1, 1'b0);
    reset_mid_cycle();
    idle(2, 1'b1, 1'b0);
    send_word(8'hC3, 1'b1, 1'b1);
    idle(2, 1'b1, 1'b0);
    send_word(8'h77, 1'b0, 1'b0);
    send_word(8'h88, 1'b0, 1'b0);
    reset_mid_cycle();
    idle(3, 1'b1, 1'b0);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      cycle(($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
    end
    // sustained one-bit-per-cycle with ready held high must never drop
    idle(2, 1'b1, 1'b1);
    for (int n = 0; n < 10 * W; n++) cycle(1'b1, 1'($urandom), 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b0);

    chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_deframer.md
Name: sipo_deframer

Overview:
- Serial-to-parallel collector that sits directly downstream of the 8-bit serial shift stage.
- Consumes its one-bit serial output, qualified by a bit-enable, and assembles WIDTH-bit words LSB-first.
- Presents completed words on a valid/ready handshake through a one-word holding register.
- Flags words lost to backpressure with a sticky overrun bit.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous active-low reset; clears all state.
- bit_valid  input  1  high = s_in carries a valid bit this cycle.
- s_in  input  1  serial data bit, LSB of each word first.
- flush  input  1  synchronous frame restart; discards the partial word.
- word_ready  input  1  consumer accepts word_out this cycle.
- clr_ovr  input  1  synchronous clear of overrun.
- word_out  output  WIDTH  assembled word; held stable while word_valid=1.
- word_valid  output  1  word_out holds an unconsumed word.
- overrun  output  1  sticky: a completed word was dropped.
- bit_count  output  CNT_W  bits collected in the current partial word.

Behaviour:
- Reset (clear=0, asynchronous): shift_reg=0, bit_count=0, word_out=0, word_valid=0, overrun=0, regardless of clk.
- Capture:
  - On a rising edge with bit_valid=1 and flush=0: shift_reg <= {s_in, shift_reg[WIDTH-1:1]}.
  - bit_count increments.
  - The first bit received lands in bit 0 after WIDTH bits.
- Gaps: bit_valid=0 holds shift_reg and bit_count; gaps of any length inside a word are legal.
- Word completion: an edge where bit_valid=1 and bit_count==WIDTH-1.
  - Assembled word C = {s_in, shift_reg[WIDTH-1:1]}.
  - bit_count wraps to 0.
  - shift_reg still takes the shifted value; it is overwritten by the next word.
- Holding register:
  - drain = word_valid & word_ready.
  - On completion, if word_valid=0 or drain=1: word_out <= C and word_valid <= 1.
  - Latency: word_valid rises on the edge that captures the WIDTH-th bit and is visible in the following cycle.
  - On completion with word_valid=1 and word_ready=0: C is dropped, word_out and word_valid are unchanged, and overrun <= 1.
  - Drain with no completion: word_valid <= 0; word_out retains its last value.
  - Simultaneous drain and completion is back-to-back: word_valid stays 1 and word_out takes C. Sustained one-bit-per-cycle input with word_ready=1 never loses words.
- flush:
  - Sets bit_count=0 and shift_reg=0.
  - Has priority over bit_valid in the same cycle; that bit is discarded.
  - Does not touch word_out, word_valid or overrun; a drain in the same cycle still completes.
- overrun:
  - Set-dominant: if a drop and clr_ovr=1 occur in the same cycle, overrun=1.
  - Otherwise clr_ovr=1 clears it.
- Reset mid-word or mid-handshake: the partial word and any held word are lost; no word_valid pulse follows reset.
- word_out must not change while word_valid=1 && word_ready=0.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset check: assert clear=0 mid-cycle -> all outputs 0 immediately, before the next clk edge.
- Basic word: stream bits 1,0,1,0,0,1,0,1 with bit_valid=1 on consecutive cycles and word_ready=1 -> word_out=8'hA5, word_valid=1 for exactly one cycle, one cycle after the 8th bit edge; bit_count sequence 1..7 then 0.
- Gapped input: send 8'h3C LSB-first with bit_valid low for 3 cycles between bits 2/3 and 6/7 -> word_out=8'h3C, bit_count frozen during gaps.
- Backpressure / overrun:
  - With word_ready=0, send 8'h11 then 8'h22 -> word_out stays 8'h11, word_valid=1, overrun=1.
  - Raise word_ready -> word_valid drops the next cycle.
  - Pulse clr_ovr -> overrun=0.
- Back-to-back drain: continuous bits for 8'hF0 then 8'h0F, with word_ready=1 on the completion cycle of the second word -> word_valid stays 1 across the boundary, word_out goes 8'hF0 then 8'h0F, overrun=0.
- Flush / reset mid-frame:
  - Send 3 bits, pulse flush together with a 4th bit_valid, then send 8'h5A -> word_out=8'h5A.
  - Repeat with clear=0 after 5 bits instead of flush -> no word_valid; the next 8 bits yield the correct word.
